updown_cntr_arbiter: RTL and testbench
======================================

UPDOWN_CNTR_ARBITER -- requirements
Module: updown_cntr_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 20: maximum RUN cycles allowed per grant before the grant is aborted.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rstn  input  1  reset; synchronous, active-low.
REQ-004 req0  input  1  requester 0 wants the counter; held high until done0 or err.
REQ-005 tgt0  input  4  requester 0 target count; sampled at grant.
REQ-006 req1  input  1  requester 1 request; same rules as req0.
REQ-007 tgt1  input  4  requester 1 target count; sampled at grant.
REQ-008 cnt_in  input  4  current value of the shared 4-bit up/down synchronous counter.
REQ-009 up  output  1  counter increment command.
REQ-010 down  output  1  counter decrement command.
REQ-011 gnt0, gnt1  output  1 each  requester currently owns the counter.
REQ-012 done0, done1  output  1 each  one-cycle pulse: target reached for that requester.
REQ-013 err  output  1  one-cycle pulse: active grant timed out.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN, DONE and ERR.
REQ-016 IDLE: up=down=0 and all gnt=0; if any req is high, latch the winner's tgt into tgt_q, clear step_cnt, and go to RUN.
REQ-017 Arbitration SHALL be round-robin with a 1-bit last-served pointer: a single request wins outright; if both request, the one not last served wins; after reset requester 0 has priority.
REQ-018 RUN: gnt of the owner is 1; up = (cnt_in < tgt_q) and down = (cnt_in > tgt_q), both combinational unsigned 4-bit compares; up and down are never both 1.
REQ-019 RUN with cnt_in == tgt_q: up=down=0 and the next state is DONE.
REQ-020 DONE lasts one cycle: owner's done pulse = 1, gnt still 1, up=down=0, last-served pointer updated to owner, next state IDLE.
REQ-021 step_cnt SHALL be at least 5 bits, increment every RUN cycle, and saturate.
REQ-022 RUN with step_cnt == TIMEOUT-1 and no match: next state is ERR.
REQ-023 ERR lasts one cycle: err=1, up=down=0, gnt=0, pointer updated to owner, next state IDLE.
REQ-024 If the owner deasserts req during RUN: the next state is IDLE, there is no done or err pulse, and the pointer is updated to the owner.
REQ-025 Target match SHALL take priority over both timeout and req withdrawal in the same cycle.
REQ-026 Wrap-around: direction is chosen by compare only, never by the shorter modular path, so the counter never passes 15->0 or 0->15 under this controller.
REQ-027 The tgt inputs of the non-owner SHALL be ignored, and changes to the owner's tgt after grant SHALL be ignored.
REQ-028 A new grant SHALL start no earlier than the cycle after the IDLE cycle (minimum one IDLE cycle between grants).

Reset
REQ-029 When rstn=0 at a clock edge: state=IDLE, pointer=requester 1 (so 0 wins the first tie), step_cnt=0, tgt_q=0.
REQ-030 During and after reset: up=down=gnt0=gnt1=done0=done1=err=busy=0.
REQ-031 A reset during RUN SHALL abort the grant with no done or err pulse; the counter itself is reset separately.

Verification
REQ-032 cnt_in=3, req0=1, tgt0=6 at cycle 0 -> RUN from cycle 1 with up=1 for three cycles (cnt 4,5,6); the next cycle is up=0 with DONE following; done0 pulses exactly once; gnt1 stays 0.
REQ-033 req0 and req1 raised together after reset, tgt0=2, tgt1=9, cnt_in=5 -> requester 0 is served first (down x3), then requester 1 (up x7); each done pulses once.
REQ-034 cnt_in held at 0 with tgt0=4 (counter disabled) -> err pulses in the cycle after 20 RUN cycles; done0 never pulses; the FSM returns to IDLE.
REQ-035 req1 dropped on the third RUN cycle -> the next state is IDLE with no done1/err, and a pending req0 is granted next.
REQ-036 rstn=0 mid-RUN -> all outputs are 0 at the next edge; after release, simultaneous requests grant requester 0.
REQ-037 tgt equal to cnt_in at grant (e.g. both 15) -> one RUN cycle with up=down=0, then a done pulse.

Source files
------------

// File: rtl/updown_cntr_arbiter.sv
// Round-robin arbiter that lets one of two requesters drive a shared 4-bit
// up/down counter towards a requested target value.
//
// Ports:
//   clk            - clock, all state updates on the rising edge
//   rstn           - synchronous active-low reset
//   req0, req1     - requests, held high until done or err
//   tgt0, tgt1     - target counts, sampled when the grant is given
//   cnt_in         - current value of the shared counter
//   up, down       - counter increment / decrement commands
//   gnt0, gnt1     - requester currently owns the counter
//   done0, done1   - one-cycle pulse, target reached for that requester
//   err            - one-cycle pulse, active grant timed out
//   busy           - controller is not idle
module updown_cntr_arbiter #(
  parameter int unsigned TIMEOUT = 20
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req0,
  input  logic [3:0] tgt0,
  input  logic       req1,
  input  logic [3:0] tgt1,
  input  logic [3:0] cnt_in,
  output logic       up,
  output logic       down,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       err,
  output logic       busy
);

  localparam int unsigned SW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
  localparam logic [SW-1:0] STEP_LAST = SW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  state_t        state, state_nxt;
  logic          owner, owner_nxt;
  logic          last, last_nxt;
  logic [3:0]    tgt_q, tgt_nxt;
  logic [SW-1:0] step_cnt, step_nxt;

  logic winner;
  logic owner_req;
  logic match;

  // A lone request wins outright; on a tie the requester not served last wins.
  always_comb begin
    winner    = (req0 & req1) ? ~last : req1;
    owner_req = owner ? req1 : req0;
    match     = (cnt_in == tgt_q);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      tgt_q    <= '0;
      step_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      last     <= last_nxt;
      tgt_q    <= tgt_nxt;
      step_cnt <= step_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    tgt_nxt   = tgt_q;
    step_nxt  = step_cnt;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_nxt = RUN;
          owner_nxt = winner;
          tgt_nxt   = winner ? tgt1 : tgt0;
          step_nxt  = '0;
        end
      end
      RUN: begin
        if (step_cnt != '1) step_nxt = step_cnt + 1'b1;
        // Match outranks timeout, timeout outranks withdrawal.
        if (match) begin
          state_nxt = DONE;
        end else if (step_cnt == STEP_LAST) begin
          state_nxt = ERR;
        end else if (!owner_req) begin
          state_nxt = IDLE;
          last_nxt  = owner;
        end
      end
      DONE, ERR: begin
        state_nxt = IDLE;
        last_nxt  = owner;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    up    = 1'b0;
    down  = 1'b0;
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    done0 = 1'b0;
    done1 = 1'b0;
    err   = 1'b0;
    busy  = (state != IDLE);
    case (state)
      RUN: begin
        gnt0 = ~owner;
        gnt1 = owner;
        up   = (cnt_in < tgt_q);
        down = (cnt_in > tgt_q);
      end
      DONE: begin
        gnt0  = ~owner;
        gnt1  = owner;
        done0 = ~owner;
        done1 = owner;
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
    // Outputs are held quiet while reset is asserted, even before the first edge.
    if (!rstn) begin
      up    = 1'b0;
      down  = 1'b0;
      gnt0  = 1'b0;
      gnt1  = 1'b0;
      done0 = 1'b0;
      done1 = 1'b0;
      err   = 1'b0;
      busy  = 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_cntr_arbiter.sv
// Self-checking bench for updown_cntr_arbiter: a directed vector table,
// hand-written multi-cycle scenarios and a randomized run against a
// behavioural model of the controller and the shared counter.
module tb_updown_cntr_arbiter;

  localparam int unsigned TIMEOUT = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, req0, req1;
  logic [3:0] tgt0, tgt1, cnt_in;
  logic       up, down, gnt0, gnt1, done0, done1, err, busy;

  updown_cntr_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .req0(req0), .tgt0(tgt0), .req1(req1), .tgt1(tgt1),
    .cnt_in(cnt_in), .up(up), .down(down), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .err(err), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Output vector order: {up, down, gnt0, gnt1, done0, done1, err, busy}
  function automatic logic [7:0] act_out();
    return {up, down, gnt0, gnt1, done0, done1, err, busy};
  endfunction

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 serving, 2 finished, 3 timed out
  int ph = 0, own = 0, ptr = 1, mtgt = 0, age = 0;
  bit cnt_en = 1'b0, auto_drop = 1'b0;

  function automatic logic [7:0] exp_out();
    logic [7:0] e;
    e = '0;
    if (!rstn) return e;
    if (ph == 1) begin
      e[7] = (int'(cnt_in) < mtgt);
      e[6] = (int'(cnt_in) > mtgt);
    end
    e[5] = (ph == 1 || ph == 2) && own == 0;
    e[4] = (ph == 1 || ph == 2) && own == 1;
    e[3] = (ph == 2) && own == 0;
    e[2] = (ph == 2) && own == 1;
    e[1] = (ph == 3);
    e[0] = (ph != 0);
    return e;
  endfunction

  task automatic model_update(input logic r, input logic q0, input logic q1,
                              input logic [3:0] t0, input logic [3:0] t1, input logic [3:0] c);
    if (!r) begin
      ph = 0; ptr = 1; age = 0; mtgt = 0;
      return;
    end
    case (ph)
      0: if (q0 || q1) begin
           if (q0 && q1) own = 1 - ptr;
           else          own = q1 ? 1 : 0;
           mtgt = own ? int'(t1) : int'(t0);
           age  = 0;
           ph   = 1;
         end
      1: begin
           if (int'(c) == mtgt)             ph = 2;
           else if (age == TIMEOUT - 1)     ph = 3;
           else if (!(own ? q1 : q0)) begin ph = 0; ptr = own; end
           if (age < 31) age = age + 1;
         end
      default: begin ptr = own; ph = 0; end
    endcase
  endtask

  // ---------------- cycle driver ----------------
  int n_up, n_down, n_done0, n_done1, n_err, n_gnt0, n_gnt1, cyc;
  int first_gnt0_cyc, err_cyc;
  int done_q[$];
  logic [7:0] last_a;

  task automatic clear_counts();
    n_up = 0; n_down = 0; n_done0 = 0; n_done1 = 0; n_err = 0;
    n_gnt0 = 0; n_gnt1 = 0; first_gnt0_cyc = -1; err_cyc = -1;
    done_q.delete();
  endtask

  task automatic run_cycle(input string tag);
    logic [7:0] e, a;
    logic r, q0, q1;
    logic [3:0] t0, t1, c;
    int o;
    @(negedge clk);
    e = exp_out();
    a = act_out();
    check(tag, {24'd0, a}, {24'd0, e});
    last_a = a;
    n_up += int'(a[7]); n_down += int'(a[6]); n_gnt0 += int'(a[5]); n_gnt1 += int'(a[4]);
    n_done0 += int'(a[3]); n_done1 += int'(a[2]); n_err += int'(a[1]);
    if (a[5] && first_gnt0_cyc < 0) first_gnt0_cyc = cyc;
    if (a[1] && err_cyc < 0) err_cyc = cyc;
    if (a[3]) done_q.push_back(0);
    if (a[2]) done_q.push_back(1);
    r = rstn; q0 = req0; q1 = req1; t0 = tgt0; t1 = tgt1; c = cnt_in; o = own;
    @(posedge clk);
    model_update(r, q0, q1, t0, t1, c);
    #1;
    cyc++;
    if (cnt_en) cnt_in = c + {3'b000, a[7]} - {3'b000, a[6]};
    if (auto_drop) begin
      if (e[3] || (e[1] && o == 0)) req0 = 1'b0;
      if (e[2] || (e[1] && o == 1)) req1 = 1'b0;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; req0 = 1'b0; req1 = 1'b0;
    run_cycle("reset");
    rstn = 1'b1;
    clear_counts();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 80 && (req0 || req1 || ph != 0); i++) run_cycle(tag);
    check({tag, "_drained"}, {31'd0, busy}, 32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rstn;
    logic       req0;
    logic [3:0] tgt0;
    logic       req1;
    logic [3:0] tgt1;
    logic [3:0] cnt;
    logic [7:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic q0, input logic [3:0] t0,
                              input logic q1, input logic [3:0] t1, input logic [3:0] c,
                              input logic [7:0] ex);
    vec_t v;
    v.rstn = r; v.req0 = q0; v.tgt0 = t0; v.req1 = q1; v.tgt1 = t1; v.cnt = c; v.exp = ex;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    // count 3 -> 6 for requester 0, late tgt change ignored
    tbl[0]  = mk(0, 0, 0,  0, 0,  3,  8'b0000_0000);
    tbl[1]  = mk(1, 1, 6,  0, 0,  3,  8'b0000_0000);
    tbl[2]  = mk(1, 1, 9,  0, 0,  3,  8'b1010_0001);
    tbl[3]  = mk(1, 1, 9,  0, 0,  4,  8'b1010_0001);
    tbl[4]  = mk(1, 1, 9,  0, 0,  5,  8'b1010_0001);
    tbl[5]  = mk(1, 1, 9,  0, 0,  6,  8'b0010_0001);
    tbl[6]  = mk(1, 1, 9,  0, 0,  6,  8'b0010_1001);
    tbl[7]  = mk(1, 0, 9,  0, 0,  6,  8'b0000_0000);
    // target equals count at grant (15 == 15)
    tbl[8]  = mk(1, 0, 0,  1, 15, 15, 8'b0000_0000);
    tbl[9]  = mk(1, 0, 0,  1, 0,  15, 8'b0001_0001);
    tbl[10] = mk(1, 0, 0,  1, 0,  15, 8'b0001_0101);
    tbl[11] = mk(1, 0, 0,  0, 0,  15, 8'b0000_0000);
    // tie after requester 1 was served: requester 0 wins, then 1
    tbl[12] = mk(1, 1, 1,  1, 1,  1,  8'b0000_0000);
    tbl[13] = mk(1, 1, 1,  1, 1,  1,  8'b0010_0001);
    tbl[14] = mk(1, 1, 1,  1, 1,  1,  8'b0010_1001);
    tbl[15] = mk(1, 0, 1,  1, 1,  1,  8'b0000_0000);
    tbl[16] = mk(1, 0, 1,  1, 1,  1,  8'b0001_0001);

    rstn = 1'b0; req0 = 1'b0; req1 = 1'b0; tgt0 = '0; tgt1 = '0; cnt_in = '0;
    cyc = 0;
    clear_counts();

    for (int i = 0; i < 17; i++) begin
      rstn = tbl[i].rstn; req0 = tbl[i].req0; tgt0 = tbl[i].tgt0;
      req1 = tbl[i].req1; tgt1 = tbl[i].tgt1; cnt_in = tbl[i].cnt;
      @(negedge clk);
      check($sformatf("vec%0d", i), {24'd0, act_out()}, {24'd0, tbl[i].exp});
      @(posedge clk);
      #1;
    end

    // simultaneous requests: 0 first (down x3 to 2), then 1 (up x7 to 9)
    auto_drop = 1'b1;
    do_reset();
    cnt_en = 1'b1; cnt_in = 4'd5;
    req0 = 1'b1; tgt0 = 4'd2; req1 = 1'b1; tgt1 = 4'd9;
    for (int i = 0; i < 60 && (req0 || req1); i++) run_cycle("tie");
    run_cycle("tie");
    check("tie_down", n_down, 3);
    check("tie_up", n_up, 7);
    check("tie_done0", n_done0, 1);
    check("tie_done1", n_done1, 1);
    check("tie_order_len", done_q.size(), 2);
    if (done_q.size() > 0) check("tie_order_first", done_q[0], 0);
    check("tie_cnt", {28'd0, cnt_in}, 32'd9);

    // frozen counter: timeout after 20 run cycles
    do_reset();
    cnt_en = 1'b0; cnt_in = 4'd0;
    req0 = 1'b1; tgt0 = 4'd4;
    for (int i = 0; i < 40 && n_err == 0; i++) run_cycle("tmo");
    run_cycle("tmo");
    check("tmo_run_cycles", n_gnt0, 20);
    check("tmo_err_delay", err_cyc - first_gnt0_cyc, 20);
    check("tmo_err_once", n_err, 1);
    check("tmo_no_done", n_done0, 0);
    check("tmo_idle", {31'd0, busy}, 32'd0);

    // requester 1 withdraws on its third run cycle, pending requester 0 follows
    do_reset();
    cnt_en = 1'b1; cnt_in = 4'd0;
    req1 = 1'b1; tgt1 = 4'd12;
    run_cycle("wd");
    req0 = 1'b1; tgt0 = 4'd3;
    run_cycle("wd");
    run_cycle("wd");
    req1 = 1'b0;
    run_cycle("wd");
    run_cycle("wd");
    check("wd_idle", {24'd0, last_a}, 32'd0);
    run_cycle("wd");
    check("wd_next_gnt0", {31'd0, last_a[5]}, 32'd1);
    check("wd_no_done1", n_done1, 0);
    check("wd_no_err", n_err, 0);
    drain("wd");

    // reset in the middle of a grant
    do_reset();
    cnt_en = 1'b1; cnt_in = 4'd0;
    req1 = 1'b1; tgt1 = 4'd15;
    run_cycle("mrst");
    run_cycle("mrst");
    run_cycle("mrst");
    rstn = 1'b0;
    run_cycle("mrst");
    rstn = 1'b1;
    check("mrst_outputs", {24'd0, act_out()}, 32'd0);
    req0 = 1'b1; tgt0 = 4'd2;
    run_cycle("mrst");
    run_cycle("mrst");
    check("mrst_gnt0", {30'd0, last_a[5:4]}, 32'd2);
    drain("mrst");

    // randomized protocol-respecting traffic
    do_reset();
    cnt_en = 1'b1;
    for (int i = 0; i < 800; i++) begin
      rstn = ($urandom_range(199) != 0);
      if (!rstn && $urandom_range(1) == 0) cnt_in = 4'($urandom);
      if (!req0 && $urandom_range(3) == 0) begin req0 = 1'b1; tgt0 = 4'($urandom); end
      if (!req1 && $urandom_range(3) == 0) begin req1 = 1'b1; tgt1 = 4'($urandom); end
      if (req0 && $urandom_range(7) == 0) tgt0 = 4'($urandom);
      if (req1 && $urandom_range(7) == 0) tgt1 = 4'($urandom);
      if (req0 && $urandom_range(39) == 0) req0 = 1'b0;
      if (req1 && $urandom_range(39) == 0) req1 = 1'b0;
      if ($urandom_range(49) == 0) cnt_en = ~cnt_en;
      run_cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
